uart_line_responder: RTL and testbench

Byte-stream responder that sits on the AXI-stream side of the `uart` block. It consumes received bytes from the `uart` RX output (`m_axis_*`) and buffers one line. It then sends the line back, upper-cased, into the `uart` TX input (`s_axis_*`). It closes the UART loop in hardware, so a serial host sees every line echoed in capitals without software in the path.

---
 rtl/uart_line_responder.sv | 135 +++++++++++++
 tb/tb_uart_line_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_responder.sv
// Line-buffering UART responder: collects one line from the RX stream and
// echoes it back upper-cased on the TX stream, always ending with one TERM.
module uart_line_responder #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  TERM  = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] line_count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  typedef enum logic [1:0] {RECV, SEND, SEND_TERM, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic            noterm_q, noterm_d;
  logic            s_ready_q, s_ready_d;
  logic            m_valid_q, m_valid_d;
  logic [7:0]      m_data_q, m_data_d;
  logic [15:0]     line_count_q, line_count_d;
  logic            wr_en;
  logic            ovf;
  logic [7:0]      buf_q [DEPTH];

  function automatic logic [7:0] upcase(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    noterm_d     = noterm_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    line_count_d = line_count_q;
    wr_en        = 1'b0;
    ovf          = 1'b0;
    case (state_q)
      RECV: begin
        if (s_ready_q && s_axis_tvalid) begin
          wr_en = 1'b1;
          wr_d  = wr_q + PW'(1);
          if (s_axis_tdata == TERM) begin
            state_d = SEND;
          end else if (wr_q == PW'(DEPTH - 1)) begin
            ovf      = 1'b1;
            noterm_d = 1'b1;
            state_d  = SEND;
          end
        end
      end
      SEND: begin
        // Output register reloads whenever it is empty or being drained, so
        // beats stream back-to-back, including the hand-off to the added TERM.
        if (!m_valid_q || m_axis_tready) begin
          if (rd_q != wr_q) begin
            m_data_d  = upcase(buf_q[rd_q[AW-1:0]]);
            m_valid_d = 1'b1;
            rd_d      = rd_q + PW'(1);
          end else if (noterm_q) begin
            m_data_d  = TERM;
            m_valid_d = 1'b1;
            state_d   = SEND_TERM;
          end else begin
            m_valid_d = 1'b0;
            state_d   = DONE;
          end
        end
      end
      SEND_TERM: begin
        if (m_axis_tready) begin
          m_valid_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        wr_d         = '0;
        rd_d         = '0;
        noterm_d     = 1'b0;
        line_count_d = line_count_q + 16'd1;
        state_d      = RECV;
      end
      default: state_d = RECV;
    endcase
    s_ready_d = (state_d == RECV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RECV;
      wr_q         <= '0;
      rd_q         <= '0;
      noterm_q     <= 1'b0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      line_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      noterm_q     <= noterm_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      line_count_q <= line_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_q[AW-1:0]] <= s_axis_tdata;
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign busy          = (state_q != RECV);
  assign overflow      = ovf;
  assign line_count    = line_count_q;

endmodule

// File: tb/tb_uart_line_responder.sv
// Directed and randomized bench for uart_line_responder with a line-level
// reference model and a concurrent output/handshake monitor.
module tb_uart_line_responder;

  localparam logic [7:0] TERM = 8'h0A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
  logic        overflow;
  logic [15:0] line_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  line_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];
  logic [15:0] lines_exp = '0;
  int          acc_cnt = 0;
  int          ovf_pulses = 0;
  int          ovf_at = 0;
  int          overlap = 0;
  logic        stalled = 1'b0;
  logic [7:0]  held = '0;
  logic        bp_mode = 1'b0;

  uart_line_responder #(.DEPTH(16), .TERM(TERM)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .busy(busy), .overflow(overflow), .line_count(line_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] up(input logic [7:0] b);
    if (b inside {[8'h61:8'h7A]}) return b - 8'h20;
    return b;
  endfunction

  // Expected response: every byte capitalised; a line cut short by a full
  // buffer gets a TERM appended.
  function automatic void build_exp();
    exp_q.delete();
    foreach (line_q[i]) exp_q.push_back(up(line_q[i]));
    if (line_q.size() == 0 || line_q[line_q.size()-1] != TERM) exp_q.push_back(TERM);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) acc_cnt++;
      if (overflow) begin
        ovf_pulses++;
        ovf_at = (s_valid && s_ready) ? acc_cnt : -1;
      end
      if (m_valid && s_ready) overlap++;
      if (stalled) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, held});
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        stalled = 1'b0;
      end else if (m_valid) begin
        stalled = 1'b1;
        held = m_data;
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n_exp);
    int k;
    k = 0;
    while (got.size() < n_exp && k < 2000) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_line(input string name, input int gapmax);
    @(posedge clk); #1;
    acc_cnt = 0;
    ovf_pulses = 0;
    overlap = 0;
    got.delete();
    build_exp();
    foreach (line_q[i]) send_byte(line_q[i], $urandom_range(0, gapmax));
    wait_resp(exp_q.size());
    lines_exp = lines_exp + 16'd1;
    check({name, "_beats"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_beat%0d", name, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    check({name, "_count"}, {16'd0, line_count}, {16'd0, lines_exp});
    check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_idle_ready"}, {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_count", {16'd0, line_count}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ready", {31'd0, s_ready}, 32'd1);

    line_q.delete(); push_str("hello world"); line_q.push_back(TERM);
    run_line("basic", 49);
    check("basic_no_ovf", ovf_pulses, 0);

    line_q.delete();
    repeat (16) line_q.push_back(8'h61);
    run_line("ovf", 3);
    check("ovf_pulses", ovf_pulses, 1);
    check("ovf_at_16th", ovf_at, 16);

    line_q.delete();
    line_q.push_back(8'h60); line_q.push_back(8'h61); line_q.push_back(8'h7A);
    line_q.push_back(8'h7B); line_q.push_back(8'h40); line_q.push_back(TERM);
    run_line("bounds", 2);

    line_q.delete(); line_q.push_back(TERM);
    run_line("empty", 0);

    for (int r = 0; r < 3; r++) begin
      int len;
      logic [7:0] b;
      line_q.delete();
      len = $urandom_range(0, 20);
      for (int i = 0; i < len && i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          b = 8'($urandom_range(0, 255));
          if (b == TERM) b = 8'hE1;
        end else begin
          b = 8'h61 + 8'($urandom_range(0, 25));
        end
        line_q.push_back(b);
      end
      if (len < 16) line_q.push_back(TERM);
      run_line($sformatf("rand%0d", r), 4);
    end

    force dut.line_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.line_count_q;
    @(negedge clk);
    lines_exp = 16'hFFFF;
    check("forced_count", {16'd0, line_count}, 32'h0000FFFF);
    line_q.delete(); line_q.push_back(TERM);
    run_line("wrap", 0);

    line_q.delete(); push_str("abc"); line_q.push_back(TERM);
    bp_mode = 1'b1;
    run_line("bp", 2);
    bp_mode = 1'b0;
    check("bp_no_overlap", overlap, 0);

    // Interrupt a response with a one-edge reset on its third beat.
    line_q.delete(); push_str("qrstuv"); line_q.push_back(TERM);
    @(posedge clk); #1;
    got.delete();
    foreach (line_q[i]) send_byte(line_q[i], 0);
    begin
      int k;
      k = 0;
      while (got.size() < 2 && k < 300) begin @(negedge clk); k++; end
      check("rs_two_beats", got.size(), 2);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rs_m_valid", {31'd0, m_valid}, 32'd0);
    check("rs_count", {16'd0, line_count}, 32'd0);
    @(negedge clk);
    check("rs_ready", {31'd0, s_ready}, 32'd1);
    lines_exp = '0;
    line_q.delete(); push_str("x"); line_q.push_back(TERM);
    run_line("after_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
